// File: rtl/button_pulse_gen.sv
// Push-button conditioner: synchronises btn_in into clk_g, debounces press and release,
// and emits single-cycle press strobes (with optional auto-repeat) plus a release strobe.
module button_pulse_gen #(
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 24,
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 5000000,
  parameter int REPEAT_PERIOD = 2500000
) (
  input  logic clk_g,
  input  logic rst_n,
  input  logic en,
  input  logic btn_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic btn_level,
  output logic repeating
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REPEAT,
    RELEASE_DB
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               RPT_ON   = (REPEAT_EN != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   press_d, release_d;

  // The synchroniser keeps running while en is low, so a button already held
  // when en rises is seen on the very next edge.
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      // NOTE: every flop uses <= so all registers update from the same pre-edge values.
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end else if (RPT_ON && cnt_q == RD_LAST) begin
          state_d = REPEAT;
          cnt_d   = '0;
          press_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          // Saturating so a long hold without auto-repeat never wraps the counter.
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      REPEAT: begin
        if (!btn_s) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end else if (cnt_q == RP_LAST) begin
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RELEASE_DB: begin
        if (btn_s) begin
          // Release bounce: back to HELD with the repeat delay restarted.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
    end
  end

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      btn_level     <= 1'b0;
      repeating     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      btn_level     <= (state_d == HELD) || (state_d == REPEAT) || (state_d == RELEASE_DB);
      repeating     <= (state_d == REPEAT);
    end
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen: directed scenarios plus random button
// activity, compared every cycle against a run-length / elapsed-time reference model.
module tb_button_pulse_gen;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;

  logic clk_g = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic btn_in = 1'b0;
  logic press_pulse, release_pulse, btn_level, repeating;

  button_pulse_gen #(
    .SYNC_STAGES  (SYNC),
    .CNT_W        (8),
    .DB_CYCLES    (DB),
    .REPEAT_EN    (1),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk_g        (clk_g),
    .rst_n        (rst_n),
    .en           (en),
    .btn_in       (btn_in),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .btn_level    (btn_level),
    .repeating    (repeating)
  );

  always #5 clk_g = ~clk_g;

  int checks = 0;
  int errors = 0;

  // Reference model: delayed samples, a run of samples disagreeing with the
  // debounced level, and edges elapsed since the last press/repeat pulse.
  bit m_pipe[SYNC];
  bit m_level, m_rep, m_press, m_release;
  int m_run, m_since;

  int edge_no, n_press, n_release, first_press, second_press, first_release, first_rep;
  bit seen_level;
  logic [15:0] led;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function void model_reset();
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
    m_level = 0; m_rep = 0; m_press = 0; m_release = 0;
    m_run = 0; m_since = 0;
  endfunction

  function void model_step(bit r, bit e, bit b);
    bit s;
    if (!r) begin
      model_reset();
      return;
    end
    s = m_pipe[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = b;
    m_press = 0;
    m_release = 0;
    if (!e) begin
      m_level = 0; m_rep = 0; m_run = 0; m_since = 0;
    end else if (!m_level) begin
      if (s) begin
        m_run++;
        if (m_run == DB + 1) begin
          m_level = 1; m_run = 0; m_since = 0; m_rep = 0; m_press = 1;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (!s) begin
        m_run++;
        m_rep = 0;
        if (m_run == DB + 1) begin
          m_level = 0; m_run = 0; m_release = 1;
        end
      end else if (m_run > 0) begin
        m_run = 0; m_since = 0; m_rep = 0;
      end else begin
        m_since++;
        if ((!m_rep && m_since == RD) || (m_rep && m_since == RP)) begin
          m_press = 1; m_rep = 1; m_since = 0;
        end
      end
    end
  endfunction

  task automatic check_outputs();
    check("press_pulse", press_pulse, m_press);
    check("release_pulse", release_pulse, m_release);
    check("btn_level", btn_level, m_level);
    check("repeating", repeating, m_rep);
  endtask

  task automatic start();
    edge_no = 0; n_press = 0; n_release = 0;
    first_press = -1; second_press = -1; first_release = -1; first_rep = -1;
    seen_level = 0;
  endtask

  task automatic tick();
    bit r, e, b;
    r = rst_n; e = en; b = btn_in;
    @(posedge clk_g);
    model_step(r, e, b);
    #1;
    check_outputs();
    if (press_pulse === 1'b1) begin
      n_press++;
      led = {led[14:0], 1'b1};
      if (first_press < 0) first_press = edge_no;
      else if (second_press < 0) second_press = edge_no;
    end
    if (release_pulse === 1'b1) begin
      n_release++;
      if (first_release < 0) first_release = edge_no;
    end
    if (repeating === 1'b1 && first_rep < 0) first_rep = edge_no;
    if (btn_level === 1'b1) seen_level = 1;
    edge_no++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    model_reset();
    start();
    led = '0;
    #1;
    check_outputs();
    run(2);
    rst_n = 1'b1;
    en = 1'b1;
    run(3);

    // 1: clean press held 8 cycles, then release
    start();
    btn_in = 1'b1; run(8);
    btn_in = 1'b0; run(12);
    check_int("s1_press_edge", first_press, SYNC + DB);
    check_int("s1_press_count", n_press, 1);
    check_int("s1_release_edge", first_release, 8 + SYNC + DB);
    check_int("s1_release_count", n_release, 1);
    check_int("s1_no_repeat", first_rep, -1);

    // 2: bounce shorter than the debounce window
    start();
    btn_in = 1'b1; run(3);
    btn_in = 1'b0; run(2);
    btn_in = 1'b1; run(3);
    btn_in = 1'b0; run(10);
    check_int("s2_press_count", n_press, 0);
    check_int("s2_level_seen", int'(seen_level), 0);

    // 3: long hold with auto-repeat
    start();
    btn_in = 1'b1; run(40);
    btn_in = 1'b0; run(12);
    check_int("s3_first_press", first_press, SYNC + DB);
    check_int("s3_second_press", second_press, SYNC + DB + RD);
    check_int("s3_repeat_start", first_rep, SYNC + DB + RD);
    check_int("s3_press_count", n_press, 1 + 1 + (40 - 6 - 10) / 3);
    check_int("s3_release_count", n_release, 1);

    // 4: en gating while the button is held
    start();
    en = 1'b0; btn_in = 1'b1; run(6);
    check_int("s4_gated_press", n_press, 0);
    start();
    en = 1'b1; run(8);
    check_int("s4_enable_press_edge", first_press, DB);
    start();
    en = 1'b0; run(3);
    check_int("s4_drop_release", n_release, 0);
    check_int("s4_drop_press", n_press, 0);
    start();
    en = 1'b1; run(8);
    check_int("s4_reenable_press", n_press, 1);
    btn_in = 1'b0; run(12);
    check_int("s4_final_release", n_release, 1);

    // 5: asynchronous reset while repeating
    start();
    btn_in = 1'b1; run(20);
    check("s5_in_repeat", repeating, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    run(2);
    rst_n = 1'b1;
    start();
    run(10);
    check_int("s5_post_reset_press", first_press, SYNC + DB);
    btn_in = 1'b0; run(12);

    // 6: fifteen clean presses stepping the LED index
    start();
    led = '0;
    for (int k = 0; k < 15; k++) begin
      btn_in = 1'b1; run(7);
      btn_in = 1'b0; run(10);
    end
    check_int("s6_press_count", n_press, 15);
    check_int("s6_release_count", n_release, 15);
    check_int("s6_led", int'(led), 32'h7FFF);

    // Random button activity with occasional en drops
    start();
    for (int k = 0; k < 60; k++) begin
      btn_in = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 9) != 0);
      run($urandom_range(1, 14));
    end
    en = 1'b1; btn_in = 1'b0; run(20);
    check("rand_final_level", btn_level, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
